// File: rtl/elau_arith_pkg.sv
// Shared arithmetic helpers for the bit-density datapath.
// Contents:
//   log2floor(n)         - index of the highest set bit of n (n > 0)
//   cnt_w(depth)         - width of a ones-count of a depth-bit word
//   acc_w(depth, fbits)  - frame-sum width: count width plus frame headroom
//   words_w(fbits)       - frame word-count width
package elau_arith_pkg;

    function automatic int log2floor(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((n >> i) > 1) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int depth);
        return log2floor(depth) + 1;
    endfunction

    function automatic int acc_w(input int depth, input int fbits);
        return log2floor(depth) + 1 + fbits;
    endfunction

    function automatic int words_w(input int fbits);
        return fbits + 1;
    endfunction

endpackage

// File: rtl/popcnt_frame_acc_cnt.sv
// Cnt: combinational ones counter for a depth-bit word.
// Parameters:
//   depth - word width (> 1)
//   speed - 0: linear ripple of single-bit additions, 1: balanced adder tree
// Ports:
//   a_i   in  depth        word to count
//   cnt_o out cnt_w(depth) number of ones in a_i
module Cnt
    import elau_arith_pkg::*;
#(
    parameter int depth = 18,
    parameter int speed = 0
) (
    input  logic [depth-1:0]        a_i,
    output logic [cnt_w(depth)-1:0] cnt_o
);

    localparam int CW = cnt_w(depth);

    if (speed == 0) begin : g_linear
        always_comb begin
            logic [CW-1:0] s;
            s = '0;
            for (int i = 0; i < depth; i++) begin
                s = s + CW'(a_i[i]);
            end
            cnt_o = s;
        end
    end else begin : g_tree
        // Leaves padded up to a power of two; node i sums children 2i and 2i+1.
        localparam int N = 1 << $clog2(depth);
        always_comb begin
            logic [N-1:0]  pad;
            logic [CW-1:0] tree [1:2*N-1];
            pad = N'(a_i);
            for (int i = 0; i < N; i++) begin
                tree[N+i] = CW'(pad[i]);
            end
            for (int i = N - 1; i >= 1; i--) begin
                tree[i] = tree[2*i] + tree[2*i+1];
            end
            cnt_o = tree[1];
        end
    end

endmodule

// File: rtl/popcnt_frame_acc.sv
// popcnt_frame_acc: counts ones per accepted word, accumulates the counts over
// a frame closed by in_last_i, and emits the frame total and word count.
// Parameters:
//   depth     - bits per input word
//   speed     - Cnt structure select (0 linear, 1 tree)
//   FrameBits - frame-length headroom for the sum and word counters
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i/in_ready_o     input handshake
//   in_data_i, in_last_i      word and end-of-frame marker
//   out_valid_o/out_ready_i   result handshake; result held while stalled
//   out_sum_o                 saturating ones total of the frame
//   out_words_o               saturating word count of the frame
//   out_ovf_o                 either counter clamped during the frame
module popcnt_frame_acc
    import elau_arith_pkg::*;
#(
    parameter  int depth     = 18,
    parameter  int speed     = 0,
    parameter  int FrameBits = 8,
    localparam int CntW      = cnt_w(depth),
    localparam int AccW      = acc_w(depth, FrameBits),
    localparam int WordsW    = words_w(FrameBits)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [depth-1:0]  in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AccW-1:0]   out_sum_o,
    output logic [WordsW-1:0] out_words_o,
    output logic              out_ovf_o
);

    // Saturating adders: the MSB of the return value flags a clamp, the
    // remaining bits hold the clamped result.
    function automatic logic [AccW:0] sat_sum(input logic [AccW-1:0] a,
                                              input logic [CntW-1:0] b);
        logic [AccW:0] s;
        s = {1'b0, a} + (AccW + 1)'(b);
        if (s[AccW]) return {1'b1, {AccW{1'b1}}};
        return s;
    endfunction

    function automatic logic [WordsW:0] sat_inc(input logic [WordsW-1:0] w);
        logic [WordsW:0] s;
        s = {1'b0, w} + (WordsW + 1)'(1);
        if (s[WordsW]) return {1'b1, {WordsW{1'b1}}};
        return s;
    endfunction

    logic [CntW-1:0]   cnt_p0;
    logic [CntW-1:0]   cnt_p1;
    logic              last_p1;
    logic              vld_p1;
    logic [AccW-1:0]   acc_p2;
    logic [WordsW-1:0] words_p2;
    logic              ovf_p2;

    logic [AccW:0]     sum_n;
    logic [WordsW:0]   words_n;
    logic              advance;
    logic              accept;

    // Stage 0: combinational ones count of the presented word
    Cnt #(
        .depth (depth),
        .speed (speed)
    ) u_cnt (
        .a_i   (in_data_i),
        .cnt_o (cnt_p0)
    );

    // S2 only stalls when it must write a new result over one still waiting.
    assign advance    = !(last_p1 && out_valid_o && !out_ready_i);
    assign in_ready_o = !rst_i && (!vld_p1 || advance);
    assign accept     = in_valid_i && in_ready_o;

    assign sum_n   = sat_sum(acc_p2, cnt_p1);
    assign words_n = sat_inc(words_p2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            acc_p2      <= '0;
            words_p2    <= '0;
            ovf_p2      <= 1'b0;
            out_valid_o <= 1'b0;
            out_sum_o   <= '0;
            out_words_o <= '0;
            out_ovf_o   <= 1'b0;
        end else begin
            // Result port: drop valid on acceptance; a new load below overrides.
            if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;

            // Stage 2: accumulate, or close the frame into the result regs
            if (vld_p1 && advance) begin
                if (last_p1) begin
                    out_sum_o   <= sum_n[AccW-1:0];
                    out_words_o <= words_n[WordsW-1:0];
                    out_ovf_o   <= ovf_p2 | sum_n[AccW] | words_n[WordsW];
                    out_valid_o <= 1'b1;
                    acc_p2      <= '0;
                    words_p2    <= '0;
                    ovf_p2      <= 1'b0;
                end else begin
                    acc_p2      <= sum_n[AccW-1:0];
                    words_p2    <= words_n[WordsW-1:0];
                    ovf_p2      <= ovf_p2 | sum_n[AccW] | words_n[WordsW];
                end
            end

            // Stage 1: capture the count of an accepted word
            if (accept) begin
                cnt_p1  <= cnt_p0;
                last_p1 <= in_last_i;
                vld_p1  <= 1'b1;
            end else if (advance) begin
                vld_p1  <= 1'b0;
            end
        end
    end

endmodule
